// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Exhaustive stimulus-and-check stage for a small combinational gate.
//   Drives every input vector in ascending order, holds each one for
//   SETTLE_CYCLES cycles, samples the gate output for one cycle, and compares
//   it against EXPECT_TABLE. Reports a mismatch count and a pass flag.
//
// Parameters
//   N_IN          number of DUT inputs (1..4)
//   SETTLE_CYCLES cycles each vector is held before sampling (1..15)
//   EXPECT_TABLE  bit i = expected DUT output for dut_in == i
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle sweep request (ignored while busy)
//   dut_in     registered stimulus to the DUT, bit 0 = LSB input
//   dut_out    DUT output under check (only used in the sample cycle)
//   busy       sweep in progress
//   done       sweep complete, held until the next accepted start
//   pass       valid when done; 1 when no vector mismatched
//   err_count  number of mismatching vectors in the last sweep
//
// Optional feature (macro GATE_CHECK_FIRST_FAIL_EN)
//   first_fail_vec    vector of the first mismatch in the sweep
//   first_fail_valid  a mismatch has been captured in this sweep

module gate_truth_table_checker #(
  parameter int unsigned              N_IN          = 2,
  parameter int unsigned              SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]     EXPECT_TABLE  = 4'b1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count
`ifdef GATE_CHECK_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
`endif
);

  localparam int unsigned VEC_W = N_IN;
  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NVEC  = 1 << N_IN;

  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NVEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q,   vec_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ERR_W-1:0]   err_q,   err_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               pass_q,  pass_d;

  logic               start_accept_c;
  logic               mismatch_c;
  logic [ERR_W-1:0]   err_sampled_c;

  // A start is honoured only when no sweep is running
  assign start_accept_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Comparison of the current vector; meaningful only in S_SAMPLE
  assign mismatch_c    = (dut_out != EXPECT_TABLE[vec_q]);
  assign err_sampled_c = mismatch_c ? (err_q + ERR_W'(1)) : err_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_accept_c) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        err_d = err_sampled_c;
        if (vec_q == LAST_VEC) begin
          // Final verdict includes this last comparison
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_sampled_c == '0);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // The stimulus register is the vector counter itself
  assign dut_in    = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef GATE_CHECK_FIRST_FAIL_EN
  logic [VEC_W-1:0] ffv_q,   ffv_d;
  logic             ffval_q, ffval_d;

  // Capture the first mismatching vector; later mismatches are ignored
  always_comb begin
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    if (start_accept_c) begin
      ffv_d   = '0;
      ffval_d = 1'b0;
    end else if ((state_q == S_SAMPLE) && mismatch_c && !ffval_q) begin
      ffv_d   = vec_q;
      ffval_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
`else
  // First-fail tracking not built
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

  logic       clk;
  logic       rst_n;
  logic       start;

  // Default instance: 2-input gate checked against the OR truth table
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [2:0] err_count;

  // Second instance: OR gate checked against an AND truth table
  logic [1:0] dut_in_a;
  logic       dut_out_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] err_count_a;

  // Gate model: arbitrary truth table plus an optional glitch term
  logic [3:0] dut_tbl;
  logic       glitch;

`ifdef GATE_CHECK_FIRST_FAIL_EN
  logic [1:0] ffv, ffv_a;
  logic       ffval, ffval_a;
`endif

  int checks   = 0;
  int failures = 0;

  assign dut_out   = dut_tbl[dut_in] ^ glitch;
  assign dut_out_a = dut_in_a[0] | dut_in_a[1];

  gate_truth_table_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
`ifdef GATE_CHECK_FIRST_FAIL_EN
    ,
    .first_fail_vec   (ffv),
    .first_fail_valid (ffval)
`endif
  );

  gate_truth_table_checker #(
    .N_IN          (2),
    .SETTLE_CYCLES (2),
    .EXPECT_TABLE  (4'b1000)
  ) u_and (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_in    (dut_in_a),
    .dut_out   (dut_out_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .err_count (err_count_a)
`ifdef GATE_CHECK_FIRST_FAIL_EN
    ,
    .first_fail_vec   (ffv_a),
    .first_fail_valid (ffval_a)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tbl;
    int         exp_err;
    int         exp_pass;
    int         exp_ff;
    int         exp_ffv;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: count truth-table disagreements against 2-input OR
  function automatic void ref_model(input logic [3:0] actual,
                                    output int err, output int ff, output int ffv);
    logic [3:0] e;
    e   = 4'b1110;
    err = 0;
    ff  = 0;
    ffv = 0;
    for (int v = 0; v < 4; v++) begin
      if (actual[v] != e[v]) begin
        err++;
        if (ffv == 0) begin
          ff  = v;
          ffv = 1;
        end
      end
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},  int'(busy),      0);
    check({tag, ".done"},  int'(done),      0);
    check({tag, ".pass"},  int'(pass),      0);
    check({tag, ".dutin"}, int'(dut_in),    0);
    check({tag, ".err"},   int'(err_count), 0);
    check({tag, ".a_err"}, int'(err_count_a), 0);
`ifdef GATE_CHECK_FIRST_FAIL_EN
    check({tag, ".ffv"},   int'(ffv),   0);
    check({tag, ".ffval"}, int'(ffval), 0);
`endif
  endtask

  // One full sweep with cycle-exact checks of the stepping sequence
  task automatic run_sweep(input string tag, input logic [3:0] tbl,
                           input bit glitch_en, input bit extra_starts,
                           input int exp_err, input int exp_pass,
                           input int exp_ff, input int exp_ffv);
    @(negedge clk);
    dut_tbl = tbl;
    glitch  = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) begin
        check($sformatf("%s.busy@%0d", tag, k),  int'(busy),   1);
        check($sformatf("%s.done@%0d", tag, k),  int'(done),   0);
        check($sformatf("%s.pass@%0d", tag, k),  int'(pass),   0);
        check($sformatf("%s.dutin@%0d", tag, k), int'(dut_in), k / 3);
        if (k == 0) begin
          check($sformatf("%s.err_clr", tag), int'(err_count), 0);
`ifdef GATE_CHECK_FIRST_FAIL_EN
          check($sformatf("%s.ffval_clr", tag), int'(ffval), 0);
`endif
        end
      end else begin
        check($sformatf("%s.done@12", tag), int'(done), 1);
        check($sformatf("%s.busy@12", tag), int'(busy), 0);
      end
      if (k == 12) break;
      @(negedge clk);
      start  = extra_starts && (k == 3 || k == 7);
      glitch = (glitch_en && (k % 3 != 2)) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
    end
    check({tag, ".err"},  int'(err_count), exp_err);
    check({tag, ".pass"}, int'(pass),      exp_pass);
`ifdef GATE_CHECK_FIRST_FAIL_EN
    check({tag, ".ffval"}, int'(ffval), exp_ffv);
    if (exp_ffv != 0) check({tag, ".ffv"}, int'(ffv), exp_ff);
    check({tag, ".a_ffv"}, int'(ffv_a), 1);
`endif
    check({tag, ".a_err"},  int'(err_count_a), 2);
    check({tag, ".a_pass"}, int'(pass_a),      0);
    check({tag, ".a_done"}, int'(done_a),      1);
    // Results hold in DONE
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".hold_done"},  int'(done),      1);
    check({tag, ".hold_err"},   int'(err_count), exp_err);
    check({tag, ".hold_dutin"}, int'(dut_in),    3);
  endtask

  vec_t vecs[7];

  initial begin
    int e, f, fv;
    logic [3:0] rt;

    vecs[0] = '{tbl: 4'b1110, exp_err: 0, exp_pass: 1, exp_ff: 0, exp_ffv: 0};
    vecs[1] = '{tbl: 4'b0000, exp_err: 3, exp_pass: 0, exp_ff: 1, exp_ffv: 1};
    vecs[2] = '{tbl: 4'b1110, exp_err: 0, exp_pass: 1, exp_ff: 0, exp_ffv: 0};
    vecs[3] = '{tbl: 4'b1111, exp_err: 1, exp_pass: 0, exp_ff: 0, exp_ffv: 1};
    vecs[4] = '{tbl: 4'b1000, exp_err: 2, exp_pass: 0, exp_ff: 1, exp_ffv: 1};
    vecs[5] = '{tbl: 4'b0110, exp_err: 1, exp_pass: 0, exp_ff: 3, exp_ffv: 1};
    vecs[6] = '{tbl: 4'b0001, exp_err: 4, exp_pass: 0, exp_ff: 0, exp_ffv: 1};

    rst_n   = 1'b0;
    start   = 1'b0;
    glitch  = 1'b0;
    dut_tbl = 4'b1110;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven sweeps; entries 1 then 2 restart from DONE with a fixed DUT
    for (int i = 0; i < 7; i++) begin
      run_sweep($sformatf("vec%0d", i), vecs[i].tbl, 1'b0, 1'b0,
                vecs[i].exp_err, vecs[i].exp_pass, vecs[i].exp_ff, vecs[i].exp_ffv);
    end

    // Start pulses while busy must be ignored
    run_sweep("busy_start", 4'b1110, 1'b0, 1'b1, 0, 1, 0, 0);

    // Reset in the middle of a sweep, then a fresh sweep
    @(negedge clk);
    dut_tbl = 4'b1110;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("after_rst", 4'b1110, 1'b0, 1'b0, 0, 1, 0, 0);

    // Random DUT truth tables with glitches outside the sample cycle
    for (int r = 0; r < 20; r++) begin
      rt = 4'($urandom_range(0, 15));
      ref_model(rt, e, f, fv);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_sweep($sformatf("rnd%0d_t%0h", r, rt), rt, 1'b1, 1'b0,
                e, (e == 0) ? 1 : 0, f, fv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Synthesizable exhaustive stimulus-and-check stage for small combinational gates, e.g. the switch-level OR gate.
- Sits directly around the gate under test (DUT).
- Upstream, it drives every input vector in ascending order.
- Downstream, it samples the gate output after a programmable settle time and compares it with a parameterised expected truth table.
- Reports a mismatch count and a pass flag, so gate checks run on hardware or in simulation without $display inspection.

Parameters:
- N_IN, 2, number of DUT inputs; legal range 1..4.
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.
- EXPECT_TABLE, 4'b1110, expected DUT output. Bit i is the expected y when dut_in == i. Width is 2**N_IN. The default is 2-input OR.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep.
- dut_in  output  N_IN  registered stimulus to the DUT inputs; bit 0 is the LSB input.
- dut_out  input  1  DUT output being checked.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, internal vector and settle counters=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 at a rising edge moves to SETTLE. On that edge: vec=0, dut_in=0, settle counter=0, err_count=0, busy=1.
- SETTLE: the counter increments each cycle. When the counter reaches SETTLE_CYCLES-1, go to SAMPLE. dut_in is held constant throughout.
- SAMPLE: lasts exactly one cycle. At the edge leaving SAMPLE, dut_out is compared with EXPECT_TABLE[vec].
  - On mismatch, err_count increments.
  - err_count cannot overflow, because it counts at most 2**N_IN mismatches.
- Leaving SAMPLE, if vec < 2**N_IN-1: vec++, dut_in=vec+1, counter=0, go to SETTLE.
- Leaving SAMPLE, if vec == 2**N_IN-1: go to DONE with busy=0, done=1, and pass=(final err_count==0). The final err_count includes the last comparison.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises at the 2**N_IN*(SETTLE_CYCLES+1)th rising edge after the edge that accepted start.
  - With the defaults this is 12 edges.
- DONE: done, pass and err_count hold, and dut_in holds the last vector.
  - start=1 restarts the sweep exactly as from IDLE, and clears done and pass on the same edge.
- start while busy=1 is ignored and has no effect on the sequence or counts.
- Reset mid-sweep returns every output to its reset value immediately. No partial result is retained.
- dut_out is used only in SAMPLE. Glitches during SETTLE are irrelevant.
- busy and done are never high simultaneously.

Optional Feature:
- Macro: GATE_CHECK_FIRST_FAIL_EN.
- When defined:
  - Adds output first_fail_vec [N_IN-1:0] and output first_fail_valid [1].
  - On the first mismatch of a sweep, first_fail_vec captures vec and first_fail_valid is set to 1.
  - Later mismatches do not overwrite first_fail_vec.
  - Both outputs clear to 0 on reset and on an accepted start.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Defaults, DUT=a|b, single-cycle start pulse:
  - dut_in steps 0,1,2,3, each held 3 cycles.
  - done=1 exactly 12 edges after start; pass=1, err_count=0, busy=0.
- Defaults, dut_out tied 0: err_count=3, pass=0.
  - With GATE_CHECK_FIRST_FAIL_EN: first_fail_vec=1 and first_fail_valid=1.
- EXPECT_TABLE=4'b1000 (AND), DUT=OR: mismatches on vectors 1 and 2, so err_count=2 and pass=0.
- Start pulsed again at cycles 3 and 7 while busy: no restart, done still at edge 12, err_count=0.
- rst_n driven 0 at cycle 5 for 2 cycles, then start reissued:
  - All outputs are 0 during reset.
  - The new sweep begins at dut_in=0 and completes normally with pass=1.
- From DONE with the stuck-0 DUT (err_count=3), reconnect the OR DUT and pulse start:
  - done and pass drop on the start edge.
  - After 12 edges: err_count=0, pass=1.
